mp_add_seq: RTL and testbench
=============================

MP_ADD_SEQ -- requirements
Module: mp_add_seq

Interface
REQ-001 SHALL have parameter N, default 8, meaning chunk width in bits, i.e. the width of the prefix adder core.
REQ-002 SHALL have parameter K, default 4, meaning the number of chunks; operand width W = N*K; K >= 1.
REQ-003 SHALL have one clock; reset is synchronous and active-low.
REQ-004 SHALL have port: clk  input  1  rising-edge clock.
REQ-005 SHALL have port: rst_n  input  1  synchronous active-low reset.
REQ-006 SHALL have port: in_valid  input  1  operands present.
REQ-007 SHALL have port: in_ready  output  1  block can accept operands.
REQ-008 SHALL have port: A  input  W  operand A.
REQ-009 SHALL have port: B  input  W  operand B.
REQ-010 SHALL have port: Cin  input  1  carry-in.
REQ-011 SHALL have port: out_valid  output  1  result present.
REQ-012 SHALL have port: out_ready  input  1  consumer takes the result.
REQ-013 SHALL have port: Sum  output  W  result.
REQ-014 SHALL have port: Cout  output  1  final carry.
REQ-015 SHALL have port: busy  output  1  high in RUN or DONE.

Function
REQ-016 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-017 SHALL drive in_ready high only in IDLE and drive out_valid high only in DONE.
REQ-018 SHALL, on an edge where in_valid & in_ready are both high, latch A, B and Cin into registers, clear the chunk counter to 0 and go to RUN; A/B changes after that edge SHALL be ignored.
REQ-019 SHALL, in RUN, add chunk i (bits i*N+N-1 : i*N) plus the carry register through the core every cycle; write the chunk sum into result bits i; load the carry register with the core Cout; increment the counter.
REQ-020 SHALL initialise the carry register from the latched Cin at acceptance.
REQ-021 SHALL go to DONE on the edge that processes chunk K-1, so out_valid rises exactly K edges after the accepting edge; for K=1 this is one edge.
REQ-022 SHALL hold Sum and Cout stable in DONE while out_ready is low; Cout equals the final carry register.
REQ-023 SHALL, in DONE with out_ready high, go to IDLE on that edge; in_ready rises the following cycle; no overlap of accept and deliver.
REQ-024 SHALL produce Sum/Cout bit-exact to (A + B + Cin) mod 2^W and its carry-out.
REQ-025 SHALL size the counter as max(1, clog2(K)) bits; it never wraps past K-1.
REQ-026 SHALL ignore in_valid in RUN/DONE and ignore out_ready outside DONE.

Reset
REQ-027 SHALL, when rst_n is low at an edge, force state IDLE, in_ready=1 after the edge, out_valid=0, busy=0, Sum=0, Cout=0, counter=0, carry register=0.
REQ-028 SHALL abort a mid-RUN or DONE operation on reset with no output pulse; the result is discarded.

Configuration
REQ-029 SHALL support macro MP_ADD_SUB_EN.
REQ-030 SHALL, with MP_ADD_SUB_EN defined, add port sub (input, 1, latched with the operands); sub=1 inverts every B chunk, forces the initial carry to 1, ignores Cin, and Cout=1 means no borrow.
REQ-031 SHALL, without MP_ADD_SUB_EN, have no sub port and perform addition only.

Structure
REQ-032 SHALL place the state encodings (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the counter-width function in shared package mp_add_pkg.
REQ-033 SHALL instantiate exactly one sub-module, prefix_add_core: a combinational N-bit Sklansky prefix adder with ports A, B, Cin, Sum, Cout.

Verification
REQ-034 SHALL cover, with N=8 and K=4: A=0xFFFFFFFF, B=0x00000001, Cin=0 -> Sum=0x00000000, Cout=1, out_valid 4 edges after accept.
REQ-035 SHALL cover: A=0x12345678, B=0x0FEDCBA9, Cin=1 -> Sum=0x22222222, Cout=0.
REQ-036 SHALL cover: out_ready held low 3 cycles in DONE -> Sum/Cout stable, in_ready=0, new in_valid ignored; release -> IDLE, in_ready=1 next cycle.
REQ-037 SHALL cover: rst_n low during RUN at counter=2 -> out_valid never rises, outputs 0; next operation 0x1+0x1 -> 0x00000002.
REQ-038 SHALL cover, with MP_ADD_SUB_EN: A=5, B=7, sub=1 -> Sum=0xFFFFFFFE, Cout=0; A=7, B=5 -> Sum=0x00000002, Cout=1.
REQ-039 SHALL cover: 1000 random back-to-back transactions with random in_valid/out_ready, including K=1 and N=4 builds -> all match the reference model.

Source files
------------

// File: rtl/mp_add_pkg.sv
// Shared state encodings and sizing helper for the sequential multi-precision adder.
package mp_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } mp_state_e;

    function automatic int cnt_w(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

endpackage

// File: rtl/mp_add_seq_core.sv
// prefix_add_core: combinational N-bit Sklansky prefix adder.
module prefix_add_core #(
    parameter int N = 8
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N-1:0] Sum,
    output logic         Cout
);

    localparam int L = (N > 1) ? $clog2(N) : 1;

    logic [L:0][N-1:0] g;
    logic [L:0][N-1:0] p;
    logic [N:0]        c;

    always_comb begin
        int j;
        j = 0;
        g = '0;
        p = '0;
        g[0] = A & B;
        p[0] = A ^ B;
        // Fold carry-in into bit 0 so every prefix already includes it
        g[0][0] = g[0][0] | (p[0][0] & Cin);
        for (int l = 0; l < L; l++) begin
            for (int i = 0; i < N; i++) begin
                if (((i >> l) & 1) == 1) begin
                    j = ((i >> l) << l) - 1;
                    g[l+1][i] = g[l][i] | (p[l][i] & g[l][j]);
                    p[l+1][i] = p[l][i] & p[l][j];
                end else begin
                    g[l+1][i] = g[l][i];
                    p[l+1][i] = p[l][i];
                end
            end
        end
        c[0] = Cin;
        for (int i = 0; i < N; i++) begin
            c[i+1] = g[L][i];
        end
    end

    assign Sum  = p[0] ^ c[N-1:0];
    assign Cout = c[N];

endmodule

// File: rtl/mp_add_seq.sv
// Sequential W=N*K adder: one N-bit chunk per cycle through a prefix core.
// Optional subtract mode is enabled with macro MP_ADD_SUB_EN.
module mp_add_seq
    import mp_add_pkg::*;
#(
    parameter int N = 8,
    parameter int K = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*K-1:0] A,
    input  logic [N*K-1:0] B,
    input  logic           Cin,
`ifdef MP_ADD_SUB_EN
    input  logic           sub,
`endif
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*K-1:0] Sum,
    output logic           Cout,
    output logic           busy
);

    localparam int CW = cnt_w(K);

    mp_state_e           state_q, state_d;
    logic [K-1:0][N-1:0] a_q, a_d;
    logic [K-1:0][N-1:0] b_q, b_d;
    logic [K-1:0][N-1:0] res_q, res_d;
    logic                carry_q, carry_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                sub_q, sub_d;
    logic [N-1:0]        b_eff;
    logic [N-1:0]        core_sum;
    logic                core_cout;

    assign b_eff = b_q[cnt_q] ^ {N{sub_q}};

    prefix_add_core #(.N(N)) u_core (
        .A    (a_q[cnt_q]),
        .B    (b_eff),
        .Cin  (carry_q),
        .Sum  (core_sum),
        .Cout (core_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sub_d   = sub_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    res_d   = '0;
                    cnt_d   = '0;
`ifdef MP_ADD_SUB_EN
                    sub_d   = sub;
                    carry_d = sub | Cin;
`else
                    sub_d   = 1'b0;
                    carry_d = Cin;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d[cnt_q] = core_sum;
                carry_d      = core_cout;
                if (cnt_q == CW'(K - 1)) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sub_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sub_q   <= sub_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign Sum       = res_q;
    assign Cout      = carry_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// Bench for mp_add_seq: directed vectors on N=8/K=4 plus random runs on three builds.
module tb_mp_add_seq;

    localparam int N = 8;
    localparam int K = 4;
    localparam int W = N * K;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int rdone_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
`ifdef MP_ADD_SUB_EN
    logic         sub = 1'b0;
`endif
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    mp_add_seq #(.N(N), .K(K)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a),
        .B         (b),
        .Cin       (cin),
`ifdef MP_ADD_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (sum),
        .Cout      (cout),
        .busy      (busy)
    );

    task automatic start(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic cv);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk("acc_rdy", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        a = av;
        b = bv;
        cin = cv;
        tick();
        in_valid = 1'b0;
        a = ~av;
        b = $urandom;
        cin = ~cv;
`ifdef MP_ADD_SUB_EN
        sub = ~sub;
`endif
    endtask

    task automatic wait_done(input string tag, input logic [W-1:0] es,
                             input logic ec);
        int lat;
        lat = 0;
        chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, lat, K);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_cout"}, {63'd0, cout}, {63'd0, ec});
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic seen;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_sum", sum, 64'd0);
        chk("rst_cout", {63'd0, cout}, 64'd0);

        start(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        wait_done("wrap", 32'h0000_0000, 1'b1);
        release_out();

        start(32'h1234_5678, 32'h0FED_CBA9, 1'b1);
        wait_done("mix", 32'h2222_2222, 1'b0);
        release_out();

        start(32'h0000_00FF, 32'h0000_0001, 1'b0);
        wait_done("hold", 32'h0000_0100, 1'b0);
        in_valid = 1'b1;
        a = 32'hDEAD_BEEF;
        b = 32'h1111_1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_sum", sum, 32'h0000_0100);
            chk("hold_cout", {63'd0, cout}, 64'd0);
            chk("hold_ov", {63'd0, out_valid}, 64'd1);
            chk("hold_ir", {63'd0, in_ready}, 64'd0);
        end
        in_valid = 1'b0;
        release_out();
        chk("rel_ov", {63'd0, out_valid}, 64'd0);
        chk("rel_ir", {63'd0, in_ready}, 64'd1);

        start(32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            seen = seen | out_valid;
            tick();
        end
        chk("abort_ov", {63'd0, seen}, 64'd0);
        chk("abort_sum", sum, 64'd0);
        chk("abort_cout", {63'd0, cout}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_ir", {63'd0, in_ready}, 64'd1);

        start(32'h0000_0001, 32'h0000_0001, 1'b0);
        wait_done("one", 32'h0000_0002, 1'b0);
        release_out();

`ifdef MP_ADD_SUB_EN
        sub = 1'b1;
        start(32'd5, 32'd7, 1'b1);
        wait_done("sub57", 32'hFFFF_FFFE, 1'b0);
        release_out();
        sub = 1'b1;
        start(32'd7, 32'd5, 1'b0);
        wait_done("sub75", 32'h0000_0002, 1'b1);
        release_out();
        sub = 1'b0;
`endif

        wait (rdone_cnt == 3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    for (genvar g = 0; g < 3; g++) begin : g_rand
        localparam int RN = (g == 2) ? 4 : 8;
        localparam int RK = (g == 1) ? 1 : 4;
        localparam int RW = RN * RK;

        logic          r_rst_n = 1'b0;
        logic          r_iv = 1'b0;
        logic          r_or = 1'b0;
        logic          r_cin = 1'b0;
        logic [RW-1:0] r_a = '0;
        logic [RW-1:0] r_b = '0;
`ifdef MP_ADD_SUB_EN
        logic          r_sub = 1'b0;
`endif
        logic          r_irdy;
        logic          r_ov;
        logic [RW-1:0] r_sum;
        logic          r_cout;
        logic          r_busy;

        mp_add_seq #(.N(RN), .K(RK)) u_dut (
            .clk       (clk),
            .rst_n     (r_rst_n),
            .in_valid  (r_iv),
            .in_ready  (r_irdy),
            .A         (r_a),
            .B         (r_b),
            .Cin       (r_cin),
`ifdef MP_ADD_SUB_EN
            .sub       (r_sub),
`endif
            .out_valid (r_ov),
            .out_ready (r_or),
            .Sum       (r_sum),
            .Cout      (r_cout),
            .busy      (r_busy)
        );

        initial begin
            logic [RW:0]   exp;
            logic [RW-1:0] bm;
            logic          cm;
            logic          pend;
            int            done;
            int            cyc;
            exp = '0;
            pend = 1'b0;
            done = 0;
            cyc = 0;
            tick();
            tick();
            r_rst_n = 1'b1;
            while (done < 1000 && cyc < 40000) begin
                r_iv = ($urandom % 2) == 0;
                r_or = ($urandom % 4) != 0;
                r_a = RW'($urandom);
                r_b = RW'($urandom);
                r_cin = $urandom % 2;
`ifdef MP_ADD_SUB_EN
                r_sub = $urandom % 2;
`endif
                if (r_ov && r_or) begin
                    chk("rand_pend", {63'd0, pend}, 64'd1);
                    chk("rand_sum", r_sum, exp[RW-1:0]);
                    chk("rand_cout", {63'd0, r_cout}, {63'd0, exp[RW]});
                    pend = 1'b0;
                    done++;
                end
                if (r_iv && r_irdy) begin
                    bm = r_b;
                    cm = r_cin;
`ifdef MP_ADD_SUB_EN
                    if (r_sub) begin
                        bm = ~r_b;
                        cm = 1'b1;
                    end
`endif
                    exp = {1'b0, r_a} + {1'b0, bm} + {{RW{1'b0}}, cm};
                    pend = 1'b1;
                end
                tick();
                cyc++;
            end
            chk("rand_done", done, 1000);
            rdone_cnt++;
        end
    end

endmodule
